rpu_ibd_seq: RTL and testbench

- Inbound packet sequencer for the RPU. Sits between the router inbound data channel and the RPU inbound buffer, next to the inbound flit decoder.
- Owns id_ready back-pressure and tracks packet boundaries using the head-flit flit count.
- Qualifies every flit as SOP/EOP, checks flit type and transaction-ID consistency, and reports packet completion or error to the RPU controller.

---
 rtl/rpu_ibd_seq.sv | 166 ++++++++++++++++
 tb/tb_rpu_ibd_seq.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rpu_ibd_seq.sv
// Inbound packet sequencer: owns id_ready, frames flits as SOP/EOP, and flags type/TID/length errors.
// Optional idle timeout inside a packet is enabled by defining NOU_IBD_TIMEOUT_EN.
//
// state  | meaning
// S_IDLE | waiting for a head flit; non-head flits are consumed and flagged
// S_BODY | packet in progress; rem counts flits still expected
module rpu_ibd_seq #(
  parameter int unsigned            TID_W   = 8,
  parameter int unsigned            TYPE_W  = 2,
  parameter int unsigned            FLIT_W  = 12,
  parameter logic [TYPE_W-1:0]      HEAD_T  = 2'd0,
  parameter logic [TYPE_W-1:0]      BODY_T  = 2'd1,
  parameter logic [TYPE_W-1:0]      TAIL_T  = 2'd2,
  parameter int unsigned            TMO_CYC = 1024
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [TID_W-1:0]  id_dat_tid,
  input  logic [TYPE_W-1:0] id_dat_type,
  input  logic [FLIT_W-1:0] pkt_flit_num,
  input  logic              buf_ready,
  output logic              id_ready,
  output logic              fwd_vld,
  output logic              fwd_sop,
  output logic              fwd_eop,
  output logic              busy,
  output logic [TID_W-1:0]  cur_tid,
  output logic              pkt_done,
  output logic              err_unexp,
  output logic              err_tid,
  output logic              err_type
);

  typedef enum logic {S_IDLE = 1'b0, S_BODY = 1'b1} state_e;

  localparam logic [FLIT_W-1:0] REM_ONE = FLIT_W'(1);

  state_e              state_q, state_d;
  logic [FLIT_W-1:0]   rem_q, rem_d;
  logic [TID_W-1:0]    cur_tid_q, cur_tid_d;
  logic                pkt_done_q, pkt_done_d;
  logic                err_unexp_q, err_unexp_d;
  logic                err_tid_q, err_tid_d;
  logic                err_type_q, err_type_d;
  logic                xfer;
  logic                is_head;
  logic                is_body;
  logic                is_tail;
  logic                last_flit;
  logic                tmo_exp;

  assign id_ready  = buf_ready;
  assign xfer      = id_valid & buf_ready;
  assign fwd_vld   = xfer;
  assign is_head   = (id_dat_type == HEAD_T);
  assign is_body   = (id_dat_type == BODY_T);
  assign is_tail   = (id_dat_type == TAIL_T);
  assign last_flit = (rem_q <= REM_ONE);

`ifdef NOU_IBD_TIMEOUT_EN
  localparam int unsigned TMO_W = (TMO_CYC > 2) ? $clog2(TMO_CYC) : 1;

  logic [TMO_W-1:0] tmo_q, tmo_d;

  assign tmo_exp = (state_q == S_BODY) && !xfer && (tmo_q == TMO_W'(TMO_CYC - 1));

  always_comb begin
    tmo_d = '0;
    if (state_q == S_BODY && !xfer && !tmo_exp) begin
      tmo_d = tmo_q + TMO_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`else
  assign tmo_exp = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    cur_tid_d   = cur_tid_q;
    pkt_done_d  = 1'b0;
    err_unexp_d = 1'b0;
    err_tid_d   = 1'b0;
    err_type_d  = 1'b0;
    fwd_sop     = 1'b0;
    fwd_eop     = 1'b0;

    if (xfer) begin
      if (is_head) begin
        // A head inside a packet abandons it and restarts framing from this flit.
        fwd_sop   = 1'b1;
        cur_tid_d = id_dat_tid;
        if (state_q == S_BODY) begin
          err_type_d = 1'b1;
        end
        if (pkt_flit_num <= REM_ONE) begin
          fwd_eop    = 1'b1;
          pkt_done_d = 1'b1;
          state_d    = S_IDLE;
          rem_d      = '0;
        end else begin
          rem_d   = pkt_flit_num - REM_ONE;
          state_d = S_BODY;
        end
      end else if (state_q == S_IDLE) begin
        err_unexp_d = 1'b1;
      end else begin
        if (id_dat_tid != cur_tid_q) begin
          err_tid_d = 1'b1;
        end
        if (last_flit || is_tail) begin
          // Closes the packet either on length or on an early tail; only a tail on the last slot is clean.
          fwd_eop    = 1'b1;
          pkt_done_d = 1'b1;
          err_type_d = !(is_tail && last_flit);
          state_d    = S_IDLE;
          rem_d      = '0;
        end else begin
          err_type_d = !is_body;
          rem_d      = rem_q - REM_ONE;
        end
      end
    end else if (tmo_exp) begin
      err_type_d = 1'b1;
      state_d    = S_IDLE;
      rem_d      = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      rem_q       <= '0;
      cur_tid_q   <= '0;
      pkt_done_q  <= 1'b0;
      err_unexp_q <= 1'b0;
      err_tid_q   <= 1'b0;
      err_type_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rem_q       <= rem_d;
      cur_tid_q   <= cur_tid_d;
      pkt_done_q  <= pkt_done_d;
      err_unexp_q <= err_unexp_d;
      err_tid_q   <= err_tid_d;
      err_type_q  <= err_type_d;
    end
  end

  assign busy      = (state_q == S_BODY);
  assign cur_tid   = cur_tid_q;
  assign pkt_done  = pkt_done_q;
  assign err_unexp = err_unexp_q;
  assign err_tid   = err_tid_q;
  assign err_type  = err_type_q;

endmodule

// File: tb/tb_rpu_ibd_seq.sv
// Directed bench for rpu_ibd_seq: inputs change on the falling edge, outputs are checked 1 ns later.
module tb_rpu_ibd_seq;

  localparam logic [1:0] HEAD_T = 2'd0;
  localparam logic [1:0] BODY_T = 2'd1;
  localparam logic [1:0] TAIL_T = 2'd2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        id_valid;
  logic [7:0]  id_dat_tid;
  logic [1:0]  id_dat_type;
  logic [11:0] pkt_flit_num;
  logic        buf_ready;
  logic        id_ready;
  logic        fwd_vld;
  logic        fwd_sop;
  logic        fwd_eop;
  logic        busy;
  logic [7:0]  cur_tid;
  logic        pkt_done;
  logic        err_unexp;
  logic        err_tid;
  logic        err_type;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rpu_ibd_seq #(.TMO_CYC(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .id_valid     (id_valid),
    .id_dat_tid   (id_dat_tid),
    .id_dat_type  (id_dat_type),
    .pkt_flit_num (pkt_flit_num),
    .buf_ready    (buf_ready),
    .id_ready     (id_ready),
    .fwd_vld      (fwd_vld),
    .fwd_sop      (fwd_sop),
    .fwd_eop      (fwd_eop),
    .busy         (busy),
    .cur_tid      (cur_tid),
    .pkt_done     (pkt_done),
    .err_unexp    (err_unexp),
    .err_tid      (err_tid),
    .err_type     (err_type)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drv(input logic v, input logic [7:0] tid, input logic [1:0] typ,
                     input logic [11:0] num, input logic br);
    @(negedge clk);
    id_valid     = v;
    id_dat_tid   = tid;
    id_dat_type  = typ;
    pkt_flit_num = num;
    buf_ready    = br;
    #1;
  endtask

  task automatic idle();
    drv(1'b0, 8'd0, BODY_T, 12'd0, 1'b1);
  endtask

  task automatic chk_flags(input string tag, input logic d, input logic u, input logic t, input logic ty);
    chk({tag, ".pkt_done"},  32'(pkt_done),  32'(d));
    chk({tag, ".err_unexp"}, 32'(err_unexp), 32'(u));
    chk({tag, ".err_tid"},   32'(err_tid),   32'(t));
    chk({tag, ".err_type"},  32'(err_type),  32'(ty));
  endtask

  initial begin
    logic eop_seen;
    rst_n = 1'b0;
    id_valid = 1'b0; id_dat_tid = '0; id_dat_type = '0; pkt_flit_num = '0; buf_ready = 1'b0;
    #12;
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.cur_tid", 32'(cur_tid), 32'd0);
    chk_flags("rst", 1'b0, 1'b0, 1'b0, 1'b0);
    chk("rst.id_ready_follows_buf", 32'(id_ready), 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Single-flit packet
    drv(1'b1, 8'd5, HEAD_T, 12'd1, 1'b1);
    chk("p1.vld", 32'(fwd_vld), 32'd1);
    chk("p1.sop", 32'(fwd_sop), 32'd1);
    chk("p1.eop", 32'(fwd_eop), 32'd1);
    idle();
    chk_flags("p1.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p1.busy", 32'(busy), 32'd0);
    chk("p1.cur_tid", 32'(cur_tid), 32'd5);
    idle();
    chk("p1.done_one_cycle", 32'(pkt_done), 32'd0);

    // Four-flit packet with buf_ready toggling
    drv(1'b1, 8'd3, HEAD_T, 12'd4, 1'b1);
    chk("p2.h.vld", 32'(fwd_vld), 32'd1);
    chk("p2.h.sop", 32'(fwd_sop), 32'd1);
    chk("p2.h.eop", 32'(fwd_eop), 32'd0);
    drv(1'b1, 8'd3, BODY_T, 12'd0, 1'b0);
    chk("p2.stall.ready", 32'(id_ready), 32'd0);
    chk("p2.stall.vld", 32'(fwd_vld), 32'd0);
    chk("p2.busy", 32'(busy), 32'd1);
    chk("p2.cur_tid", 32'(cur_tid), 32'd3);
    drv(1'b1, 8'd3, BODY_T, 12'd0, 1'b1);
    chk("p2.b1.vld", 32'(fwd_vld), 32'd1);
    chk("p2.b1.sopeop", 32'({fwd_sop, fwd_eop}), 32'd0);
    drv(1'b1, 8'd3, BODY_T, 12'd0, 1'b0);
    chk("p2.stall2.vld", 32'(fwd_vld), 32'd0);
    drv(1'b1, 8'd3, BODY_T, 12'd0, 1'b1);
    chk("p2.b2.vld", 32'(fwd_vld), 32'd1);
    chk("p2.b2.eop", 32'(fwd_eop), 32'd0);
    drv(1'b1, 8'd3, TAIL_T, 12'd0, 1'b0);
    chk("p2.stall3.vld", 32'(fwd_vld), 32'd0);
    chk("p2.stall3.eop", 32'(fwd_eop), 32'd0);
    chk("p2.stall3.busy", 32'(busy), 32'd1);
    drv(1'b1, 8'd3, TAIL_T, 12'd0, 1'b1);
    chk("p2.t.vld", 32'(fwd_vld), 32'd1);
    chk("p2.t.sopeop", 32'({fwd_sop, fwd_eop}), 32'b01);
    chk_flags("p2.t.prev", 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk_flags("p2.after", 1'b1, 1'b0, 1'b0, 1'b0);
    chk("p2.busy_end", 32'(busy), 32'd0);

    // Body flit while idle
    drv(1'b1, 8'd9, BODY_T, 12'd0, 1'b1);
    chk("p3.vld", 32'(fwd_vld), 32'd1);
    chk("p3.sop", 32'(fwd_sop), 32'd0);
    idle();
    chk_flags("p3.after", 1'b0, 1'b1, 1'b0, 1'b0);
    chk("p3.busy", 32'(busy), 32'd0);
    idle();
    chk("p3.unexp_one_cycle", 32'(err_unexp), 32'd0);

    // TID mismatch inside a packet
    drv(1'b1, 8'd7, HEAD_T, 12'd3, 1'b1);
    drv(1'b1, 8'd8, BODY_T, 12'd0, 1'b1);
    chk("p4.b.vld", 32'(fwd_vld), 32'd1);
    drv(1'b1, 8'd7, TAIL_T, 12'd0, 1'b1);
    chk_flags("p4.b.after", 1'b0, 1'b0, 1'b1, 1'b0);
    chk("p4.t.eop", 32'(fwd_eop), 32'd1);
    idle();
    chk_flags("p4.after", 1'b1, 1'b0, 1'b0, 1'b0);

    // New head abandons the current packet
    drv(1'b1, 8'd1, HEAD_T, 12'd5, 1'b1);
    drv(1'b1, 8'd1, BODY_T, 12'd0, 1'b1);
    drv(1'b1, 8'd2, HEAD_T, 12'd1, 1'b1);
    chk("p5.h2.sopeop", 32'({fwd_sop, fwd_eop}), 32'b11);
    chk("p5.h2.no_done_first", 32'(pkt_done), 32'd0);
    idle();
    chk_flags("p5.after", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("p5.cur_tid", 32'(cur_tid), 32'd2);
    chk("p5.busy", 32'(busy), 32'd0);

    // Abandon by a multi-flit head: error but no completion yet
    drv(1'b1, 8'd4, HEAD_T, 12'd3, 1'b1);
    drv(1'b1, 8'd6, HEAD_T, 12'd2, 1'b1);
    idle();
    chk_flags("p5b.after", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("p5b.busy", 32'(busy), 32'd1);
    chk("p5b.cur_tid", 32'(cur_tid), 32'd6);
    drv(1'b1, 8'd6, TAIL_T, 12'd0, 1'b1);
    chk("p5b.t.eop", 32'(fwd_eop), 32'd1);
    idle();
    chk_flags("p5b.done", 1'b1, 1'b0, 1'b0, 1'b0);

    // Early tail
    drv(1'b1, 8'd10, HEAD_T, 12'd5, 1'b1);
    drv(1'b1, 8'd10, BODY_T, 12'd0, 1'b1);
    drv(1'b1, 8'd10, TAIL_T, 12'd0, 1'b1);
    chk("p6.t.eop", 32'(fwd_eop), 32'd1);
    idle();
    chk_flags("p6.after", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("p6.busy", 32'(busy), 32'd0);

    // Last flit is a body flit instead of a tail
    drv(1'b1, 8'd11, HEAD_T, 12'd2, 1'b1);
    drv(1'b1, 8'd11, BODY_T, 12'd0, 1'b1);
    chk("p7.b.eop", 32'(fwd_eop), 32'd1);
    idle();
    chk_flags("p7.after", 1'b1, 1'b0, 1'b0, 1'b1);
    chk("p7.busy", 32'(busy), 32'd0);

    // Maximum length packet: 1 head, 4093 bodies, 1 tail
    drv(1'b1, 8'd12, HEAD_T, 12'hFFF, 1'b1);
    chk("p8.h.eop", 32'(fwd_eop), 32'd0);
    eop_seen = 1'b0;
    for (int i = 0; i < 4093; i++) begin
      drv(1'b1, 8'd12, BODY_T, 12'd0, 1'b1);
      eop_seen = eop_seen | fwd_eop | pkt_done | err_type;
    end
    chk("p8.bodies_clean", 32'(eop_seen), 32'd0);
    chk("p8.busy", 32'(busy), 32'd1);
    drv(1'b1, 8'd12, TAIL_T, 12'd0, 1'b1);
    chk("p8.t.eop", 32'(fwd_eop), 32'd1);
    idle();
    chk_flags("p8.after", 1'b1, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset mid-packet
    drv(1'b1, 8'd13, HEAD_T, 12'd4, 1'b1);
    idle();
    chk("p9.busy_pre", 32'(busy), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("p9.busy_rst", 32'(busy), 32'd0);
    chk("p9.tid_rst", 32'(cur_tid), 32'd0);
    @(negedge clk); rst_n = 1'b1;
    drv(1'b1, 8'd13, BODY_T, 12'd0, 1'b1);
    chk("p9.b.eop", 32'(fwd_eop), 32'd0);
    idle();
    chk_flags("p9.after", 1'b0, 1'b1, 1'b0, 1'b0);

`ifdef NOU_IBD_TIMEOUT_EN
    // Idle timeout inside a packet
    drv(1'b1, 8'd14, HEAD_T, 12'd3, 1'b1);
    for (int i = 0; i < 16; i++) idle();
    chk("p10.busy_before", 32'(busy), 32'd1);
    chk("p10.no_err_yet", 32'(err_type), 32'd0);
    idle();
    chk_flags("p10.tmo", 1'b0, 1'b0, 1'b0, 1'b1);
    chk("p10.busy", 32'(busy), 32'd0);
    drv(1'b1, 8'd15, HEAD_T, 12'd1, 1'b1);
    chk("p10.h.sopeop", 32'({fwd_sop, fwd_eop}), 32'b11);
    idle();
    chk_flags("p10.after", 1'b1, 1'b0, 1'b0, 1'b0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
